core_step_ctrl: RTL
===================

CORE_STEP_CTRL -- requirements
Module: core_step_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 120000 (10 ms at 12 MHz): number of stable synchronized samples required to accept a button level change; legal range >= 2.
REQ-002 SHALL have parameter SLOW_DIV, default 12000000 (1 Hz at 12 MHz): period, in clk cycles, between core_en pulses in SLOW mode; legal range >= 2.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port btn_mode, input, 1 bit: raw, asynchronous, active-high mode button.
REQ-006 SHALL have port btn_step, input, 1 bit: raw, asynchronous, active-high single-step button.
REQ-007 SHALL have port core_en, output, 1 bit, registered: clock enable for the pipelined core; the core advances one cycle per clk edge where core_en=1.
REQ-008 SHALL have port mode, output, 2 bits, registered: 2'b00 HALT, 2'b01 SLOW, 2'b10 RUN; 2'b11 never driven.
REQ-009 SHALL have port step_count, output, 16 bits, registered: number of cycles with core_en=1 since reset, modulo 2^16.

Function
REQ-010 SHALL pass each button through its own 2-flop synchronizer before any other use.
REQ-011 SHALL debounce each synchronized button independently: counter cleared while sample equals debounced level; otherwise counter increments; when counter = DEBOUNCE_CYCLES-1 with sample still differing, debounced level takes sample and counter clears.
REQ-012 SHALL produce a one-cycle registered press event on each 0->1 transition of a debounced level; releases produce no event.
REQ-013 SHALL implement a 3-state FSM in mode: HALT -> SLOW -> RUN -> HALT, advancing exactly one state per mode press event.
REQ-014 SHALL, in HALT, drive core_en=1 for exactly one cycle per step press event, and 0 otherwise.
REQ-015 SHALL, in SLOW, clear the divider on entry, increment it each cycle, and pulse core_en=1 for one cycle when divider = SLOW_DIV-1 (divider then clears); first pulse at SLOW_DIV cycles after entry.
REQ-016 SHALL, in RUN, drive core_en=1 every cycle.
REQ-017 SHALL update mode and core_en on the edge that consumes the event, so the first mode/core_en response appears DEBOUNCE_CYCLES+4 edges after the first edge sampling the raw button high (held stable).
REQ-018 SHALL, on leaving RUN for HALT, drive core_en=0 from the same edge that changes mode.
REQ-019 SHALL ignore step press events in SLOW and RUN (no core_en effect, not queued).
REQ-020 SHALL, when mode and step press events occur in the same cycle, apply the mode event and discard the step event.
REQ-021 SHALL increment step_count on every edge where core_en=1, wrapping 16'hFFFF -> 16'h0000 without flag.
REQ-022 SHALL treat a glitch shorter than DEBOUNCE_CYCLES synchronized samples as no change (no event).

Reset
REQ-023 SHALL, while reset=1 at a clk edge, set mode=HALT, core_en=0, step_count=0, divider=0, synchronizers=0, debounced levels=0, debounce counters=0, events=0.
REQ-024 SHALL abort any in-progress debounce, SLOW period or RUN on reset; a button held high through reset SHALL produce one press event after full debounce following reset release.

Verification (DEBOUNCE_CYCLES=4, SLOW_DIV=5)
REQ-025 SHALL cover: reset, btn_step high from edge 1 -> core_en=1 for exactly one cycle after edge 8, step_count=1, mode=00.
REQ-026 SHALL cover: btn_mode pulse 3 samples wide -> no event; mode stays 00, core_en stays 0.
REQ-027 SHALL cover: one clean mode press -> mode=01; core_en pulses every 5th cycle, first 5 cycles after mode change; btn_step presses have no effect.
REQ-028 SHALL cover: two more mode presses -> mode=10 with core_en=1 continuously, then mode=00 with core_en=0 on the same edge.
REQ-029 SHALL cover: mode and step pressed simultaneously in HALT -> mode=01, no extra core_en pulse; step_count preloaded near 16'hFFFF in RUN wraps to 16'h0000.
REQ-030 SHALL cover: reset asserted mid-RUN with btn_mode held -> all outputs zero/HALT after reset edge; one mode event (mode=01) after debounce post-release.

Source files
------------

// File: rtl/core_step_ctrl.sv
// Run/slow/single-step clock-enable controller for a pipelined core, driven by two
// raw push buttons (mode cycling and single step).
module core_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned SLOW_DIV        = 12000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_step,
    output logic        core_en,
    output logic [1:0]  mode,
    output logic [15:0] step_count
);
    localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned DivW = $clog2(SLOW_DIV);

    typedef enum logic [1:0] {
        StHalt = 2'b00,
        StSlow = 2'b01,
        StRun  = 2'b10
    } mode_e;

    // Bit 0 carries the mode button, bit 1 the step button.
    logic [1:0]           r_sync1;
    logic [1:0]           r_sync2;
    logic [1:0]           r_lvl;
    logic [1:0]           r_lvl_d;
    logic [1:0]           r_evt;
    logic [1:0][DbW-1:0]  r_db_cnt;

    mode_e                r_state;
    logic [DivW-1:0]      r_div;
    logic                 r_core_en;
    logic [15:0]          r_step_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_lvl    <= '0;
            r_lvl_d  <= '0;
            r_evt    <= '0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= {btn_step, btn_mode};
            r_sync2 <= r_sync1;
            r_lvl_d <= r_lvl;
            r_evt   <= r_lvl & ~r_lvl_d;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
                    r_lvl[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DbW'(1);
                end
            end
        end
    end

    // A mode event always wins; a coincident step event is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StHalt;
            r_core_en    <= 1'b0;
            r_div        <= '0;
            r_step_count <= '0;
        end else begin
            r_step_count <= r_step_count + {15'd0, r_core_en};
            if (r_evt[0]) begin
                r_div <= '0;
                case (r_state)
                    StHalt: begin
                        r_state   <= StSlow;
                        r_core_en <= 1'b0;
                    end
                    StSlow: begin
                        r_state   <= StRun;
                        r_core_en <= 1'b1;
                    end
                    default: begin
                        r_state   <= StHalt;
                        r_core_en <= 1'b0;
                    end
                endcase
            end else begin
                case (r_state)
                    StHalt: begin
                        r_core_en <= r_evt[1];
                        r_div     <= '0;
                    end
                    StSlow: begin
                        if (r_div == DivW'(SLOW_DIV - 1)) begin
                            r_div     <= '0;
                            r_core_en <= 1'b1;
                        end else begin
                            r_div     <= r_div + DivW'(1);
                            r_core_en <= 1'b0;
                        end
                    end
                    default: begin
                        r_core_en <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign core_en    = r_core_en;
    assign mode       = r_state;
    assign step_count = r_step_count;

endmodule
